// File: rtl/spart_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : spart_bus_arbiter_if
// Desc     : Requester-side req/ack handshake bundle for spart_bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface spart_bus_arbiter_if;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [7:0]  rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, err, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, err, rdata
    );
endinterface
`default_nettype wire

// File: rtl/spart_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spart_bus_arbiter
// Desc     : Round-robin two-requester arbiter and sequencer for the SPART bus.
//            Define SPART_ARB_TIMEOUT_EN to bound the tbr/rda wait.
// Revision : 1.0 - initial release
// ============================================================================
module spart_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    spart_bus_arbiter_if.slave        req_if,
    output logic                      iocs,
    output logic                      iorw,
    output logic [1:0]                ioaddr,
    inout  wire  [7:0]                databus,
    input  logic                      rda,
    input  logic                      tbr
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_WAIT_RDY = 2'd1;
    localparam logic [1:0] c_ISSUE    = 2'd2;
    localparam logic [1:0] c_DONE     = 2'd3;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_timeout_range_check
        $error("spart_bus_arbiter: TIMEOUT_CYCLES must be in 1..65536");
    end

    logic [1:0] r_state;
    logic       r_grant;
    logic       r_last_grant;
    logic       r_we;
    logic [1:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;
    logic [1:0] r_ack;
    logic       r_iocs;
    logic       r_iorw;
    logic [1:0] r_ioaddr;
    logic       r_drive;

    logic       w_grant;
    logic [1:0] w_grant_oh;
    logic       w_ready;

`ifdef SPART_ARB_TIMEOUT_EN
    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_wait_cnt;
    logic [1:0]  r_err;
    assign req_if.err = r_err;
`else
    assign req_if.err = 2'b00;
`endif

    // Tie goes to whichever requester was not served last.
    always_comb begin
        w_grant = req_if.req[1];
        if (req_if.req == 2'b11) begin
            w_grant = ~r_last_grant;
        end
    end

    // Only the data register (addr 00) is gated on SPART readiness.
    always_comb begin
        w_ready = 1'b1;
        if (r_addr == 2'b00) begin
            w_ready = r_we ? tbr : rda;
        end
    end

    assign w_grant_oh = r_grant ? 2'b10 : 2'b01;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= 2'b00;
            r_wdata      <= 8'h00;
            r_rdata      <= 8'h00;
            r_ack        <= 2'b00;
            r_iocs       <= 1'b0;
            r_iorw       <= 1'b1;
            r_ioaddr     <= 2'b00;
            r_drive      <= 1'b0;
`ifdef SPART_ARB_TIMEOUT_EN
            r_wait_cnt   <= 16'd0;
            r_err        <= 2'b00;
`endif
        end else begin
            r_ack    <= 2'b00;
            r_iocs   <= 1'b0;
            r_iorw   <= 1'b1;
            r_ioaddr <= 2'b00;
            r_drive  <= 1'b0;
`ifdef SPART_ARB_TIMEOUT_EN
            r_err    <= 2'b00;
`endif
            case (r_state)
                c_IDLE: begin
                    if (|req_if.req) begin
                        r_grant <= w_grant;
                        r_we    <= w_grant ? req_if.we[1] : req_if.we[0];
                        r_addr  <= w_grant ? req_if.addr[3:2] : req_if.addr[1:0];
                        r_wdata <= w_grant ? req_if.wdata[15:8] : req_if.wdata[7:0];
`ifdef SPART_ARB_TIMEOUT_EN
                        r_wait_cnt <= 16'd0;
`endif
                        r_state <= c_WAIT_RDY;
                    end
                end
                c_WAIT_RDY: begin
                    // Bus outputs are loaded here so they are registered in ISSUE.
                    if (w_ready) begin
                        r_iocs   <= 1'b1;
                        r_iorw   <= ~r_we;
                        r_ioaddr <= r_addr;
                        r_drive  <= r_we;
                        r_state  <= c_ISSUE;
                    end
`ifdef SPART_ARB_TIMEOUT_EN
                    else if (r_wait_cnt == c_TIMEOUT_LAST) begin
                        r_ack   <= w_grant_oh;
                        r_err   <= w_grant_oh;
                        r_state <= c_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
`endif
                end
                c_ISSUE: begin
                    if (!r_we) begin
                        r_rdata <= databus;
                    end
                    r_ack   <= w_grant_oh;
                    r_state <= c_DONE;
                end
                c_DONE: begin
                    r_last_grant <= r_grant;
                    r_state      <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign req_if.ack   = r_ack;
    assign req_if.rdata = r_rdata;
    assign iocs         = r_iocs;
    assign iorw         = r_iorw;
    assign ioaddr       = r_ioaddr;
    assign databus      = r_drive ? r_wdata : 8'hzz;

endmodule
`default_nettype wire

// File: tb/tb_spart_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spart_bus_arbiter
// Desc     : Self-checking bench for spart_bus_arbiter (vectors, corner cases,
//            randomized transactions against a transaction-level model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spart_bus_arbiter;

    localparam int c_TIMEOUT = 8;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [7:0]  sdata;
        int          d;
        logic [1:0]  e_ack;
        logic        e_iorw;
        logic [1:0]  e_ioaddr;
        logic [7:0]  e_dbus;
        int          e_lat;
        logic [7:0]  e_rdata;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rda;
    logic       tbr;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic [7:0] spart_data;

    int         total = 0;
    int         bad   = 0;
    logic       lg;
    logic [7:0] m_rdata;
    vec_t       vec [6];

    spart_bus_arbiter_if bus_if ();

    spart_bus_arbiter #(.TIMEOUT_CYCLES(c_TIMEOUT)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_if  (bus_if),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .rda     (rda),
        .tbr     (tbr)
    );

    // SPART model: drives read data while it is selected for a read.
    assign databus = (iocs && iorw) ? spart_data : 8'hzz;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_if.req = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        lg      = 1'b1;
        m_rdata = 8'h00;
    endtask

    // Starts at the beginning of the IDLE cycle with req already driven;
    // returns at the start of the cycle following ack.
    task automatic check_txn(input string tag, input int d, input logic [1:0] e_ack,
                             input logic e_iorw, input logic [1:0] e_ioaddr,
                             input logic [7:0] e_dbus, input int e_lat,
                             input logic [7:0] e_rdata, input bit chk_release);
        int issues;
        bit done;
        issues = 0;
        done   = 0;
        tbr    = 1'b0;
        rda    = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (cyc == d + 1) begin
                if (e_iorw) rda = 1'b1;
                else        tbr = 1'b1;
            end
            @(negedge clk);
            if (iocs) begin
                issues++;
                chk({tag, " issue_cycle"}, 32'(cyc), 32'(e_lat - 1));
                chk({tag, " iorw"}, 32'(iorw), 32'(e_iorw));
                chk({tag, " ioaddr"}, 32'(ioaddr), 32'(e_ioaddr));
                if (!e_iorw) chk({tag, " databus"}, 32'(databus), 32'(e_dbus));
            end else if (chk_release) begin
                total++;
                if (databus === e_dbus) begin
                    bad++;
                    $display("FAIL %s bus_released: got %0h expected not %0h", tag, databus, e_dbus);
                end
            end
            if (bus_if.ack !== 2'b00) begin
                chk({tag, " ack"}, 32'(bus_if.ack), 32'(e_ack));
                chk({tag, " latency"}, 32'(cyc), 32'(e_lat));
                chk({tag, " err"}, 32'(bus_if.err), 32'd0);
                chk({tag, " rdata"}, 32'(bus_if.rdata), 32'(e_rdata));
                chk({tag, " issue_count"}, 32'(issues), 32'd1);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s ack_wait: got none expected %0h", tag, e_ack);
        end
    endtask

    // Reference: grant g performs one bus cycle using its own fields.
    task automatic model_txn(input string tag, input logic g, input logic [1:0] wv,
                             input logic [3:0] av, input logic [15:0] dv);
        logic       w;
        logic [1:0] a;
        logic [7:0] wd;
        int         dd;
        int         lat;
        w  = wv[g];
        a  = g ? av[3:2] : av[1:0];
        wd = g ? dv[15:8] : dv[7:0];
        dd = $urandom_range(0, 4);
        lat = (a == 2'b00) ? 3 + dd : 3;
        spart_data = 8'($urandom);
        if (!w) m_rdata = spart_data;
        check_txn(tag, dd, g ? 2'b10 : 2'b01, ~w, a, wd, lat, m_rdata, 1'b0);
        lg = g;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  p;
        logic [1:0]  wv;
        logic [3:0]  av;
        logic [15:0] dv;
        logic        g;

        rst = 1'b1; rda = 1'b0; tbr = 1'b0; spart_data = 8'h00;
        bus_if.req = 2'b00; bus_if.we = 2'b00; bus_if.addr = 4'h0; bus_if.wdata = 16'h0000;

        vec[0] = '{2'b01, 2'b01, 4'b0010, 16'h0045, 8'h00, 0, 2'b01, 1'b0, 2'b10, 8'h45, 3, 8'h00};
        vec[1] = '{2'b10, 2'b00, 4'b0100, 16'h0000, 8'h5A, 0, 2'b10, 1'b1, 2'b01, 8'h00, 3, 8'h5A};
        vec[2] = '{2'b10, 2'b10, 4'b0000, 16'hC300, 8'h00, 2, 2'b10, 1'b0, 2'b00, 8'hC3, 5, 8'h5A};
        vec[3] = '{2'b01, 2'b00, 4'b0000, 16'h0000, 8'h7E, 3, 2'b01, 1'b1, 2'b00, 8'h00, 6, 8'h7E};
        vec[4] = '{2'b01, 2'b01, 4'b0011, 16'h0099, 8'h00, 4, 2'b01, 1'b0, 2'b11, 8'h99, 3, 8'h7E};
        vec[5] = '{2'b11, 2'b10, 4'b1001, 16'h6655, 8'h00, 0, 2'b10, 1'b0, 2'b10, 8'h66, 3, 8'h7E};

        do_reset();
        @(negedge clk);
        chk("reset ack", 32'(bus_if.ack), 32'd0);
        chk("reset err", 32'(bus_if.err), 32'd0);
        chk("reset rdata", 32'(bus_if.rdata), 32'd0);
        chk("reset iocs", 32'(iocs), 32'd0);
        chk("reset iorw", 32'(iorw), 32'd1);
        chk("reset ioaddr", 32'(ioaddr), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            bus_if.req   = vec[i].req;
            bus_if.we    = vec[i].we;
            bus_if.addr  = vec[i].addr;
            bus_if.wdata = vec[i].wdata;
            spart_data   = vec[i].sdata;
            check_txn($sformatf("vec%0d", i), vec[i].d, vec[i].e_ack, vec[i].e_iorw,
                      vec[i].e_ioaddr, vec[i].e_dbus, vec[i].e_lat, vec[i].e_rdata, 1'b0);
        end
        bus_if.req = 2'b00;

        // Tie from reset: requester 0 first, then strict alternation.
        do_reset();
        bus_if.req = 2'b11; bus_if.we = 2'b11; bus_if.addr = 4'b1001; bus_if.wdata = 16'h2211;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) check_txn($sformatf("tie%0d", k), 0, 2'b01, 1'b0, 2'b01, 8'h11, 3, m_rdata, 1'b0);
            else            check_txn($sformatf("tie%0d", k), 0, 2'b10, 1'b0, 2'b10, 8'h22, 3, m_rdata, 1'b0);
        end

        bus_if.req = 2'b10; bus_if.we = 2'b00; bus_if.addr = 4'b0000; spart_data = 8'hA5;
        check_txn("rx_gated", 10, 2'b10, 1'b1, 2'b00, 8'h00, 13, 8'hA5, 1'b0);
        m_rdata = 8'hA5;

        bus_if.req = 2'b01; bus_if.we = 2'b01; bus_if.addr = 4'b0000; bus_if.wdata = 16'h003C;
        check_txn("tx_gated", 5, 2'b01, 1'b0, 2'b00, 8'h3C, 8, 8'hA5, 1'b1);
        lg = 1'b0;

        // Reset while waiting for rda; last grant must return to 1.
        bus_if.req = 2'b10; bus_if.we = 2'b00; bus_if.addr = 4'b0000;
        tbr = 1'b0; rda = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; bus_if.req = 2'b00;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst iocs", 32'(iocs), 32'd0);
        chk("midrst ack", 32'(bus_if.ack), 32'd0);
        lg = 1'b1; m_rdata = 8'h00;
        @(posedge clk); #1;
        bus_if.req = 2'b11; bus_if.we = 2'b11; bus_if.addr = 4'b0101; bus_if.wdata = 16'hBBAA;
        check_txn("midrst tie0", 0, 2'b01, 1'b0, 2'b01, 8'hAA, 3, 8'h00, 1'b0);
        bus_if.req = 2'b10;
        check_txn("midrst tie1", 0, 2'b10, 1'b0, 2'b01, 8'hBB, 3, 8'h00, 1'b0);
        lg = 1'b1;

        for (int it = 0; it < 40; it++) begin
            p  = 2'($urandom_range(1, 3));
            wv = 2'($urandom);
            av = 4'($urandom);
            dv = 16'($urandom);
            bus_if.req = p; bus_if.we = wv; bus_if.addr = av; bus_if.wdata = dv;
            g = (p == 2'b11) ? ~lg : p[1];
            model_txn($sformatf("rnd%0d a", it), g, wv, av, dv);
            if (p == 2'b11) begin
                bus_if.req = g ? 2'b01 : 2'b10;
                model_txn($sformatf("rnd%0d b", it), ~g, wv, av, dv);
            end
            bus_if.req = 2'b00;
        end

`ifdef SPART_ARB_TIMEOUT_EN
        begin
            int  seen;
            bit  got;
            seen = 0;
            got  = 0;
            bus_if.req = 2'b01; bus_if.we = 2'b00; bus_if.addr = 4'b0000;
            tbr = 1'b0; rda = 1'b0;
            for (int cyc = 0; cyc < 40 && !got; cyc++) begin
                @(negedge clk);
                if (iocs) seen++;
                if (bus_if.ack !== 2'b00) begin
                    chk("timeout ack", 32'(bus_if.ack), 32'd1);
                    chk("timeout err", 32'(bus_if.err), 32'd1);
                    chk("timeout latency", 32'(cyc), 32'(c_TIMEOUT + 1));
                    chk("timeout rdata", 32'(bus_if.rdata), 32'(m_rdata));
                    chk("timeout iocs_count", 32'(seen), 32'd0);
                    got = 1;
                end
                @(posedge clk);
                #1;
            end
            if (!got) begin
                total++;
                bad++;
                $display("FAIL timeout ack_wait: got none expected 1");
            end
            bus_if.req = 2'b00;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spart_bus_arbiter.md
# spart_bus_arbiter

Two-requester arbiter and sequencer for the single SPART processor bus (`iocs`/`iorw`/`ioaddr`/`databus`). It sits between the SPART and two bus masters, for example an echo driver and a baud-configuration or logging master. Each master issues one transaction at a time through a simple req/ack handshake. The arbiter grants round-robin, waits for SPART readiness (`tbr` for TX writes, `rda` for RX reads), runs exactly one bus cycle, and returns read data.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 4096: maximum cycles spent waiting for `tbr`/`rda`; only used when `SPART_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  2  per-requester request; bit N is requester N; level, held until ack.
- `we`  in  2  per-requester op; 1 = write, 0 = read.
- `addr`  in  4  `{addr1, addr0}`, 2 bits each; SPART register address.
- `wdata`  in  16  `{wdata1, wdata0}`, 8 bits each.
- `ack`  out  2  one-cycle completion pulse to the granted requester.
- `err`  out  2  valid with `ack`; 1 = transaction aborted by timeout.
- `rdata`  out  8  read data; valid in the `ack` cycle of a read, held until the next read completes.
- `iocs`  out  1  SPART chip select.
- `iorw`  out  1  1 = read, 0 = write.
- `ioaddr`  out  2  SPART register address.
- `databus`  inout  8  driven only during a write ISSUE cycle, otherwise `8'hZZ`.
- `rda`  in  1  SPART receive data available.
- `tbr`  in  1  SPART transmit buffer ready.

## Operation
- **States:** IDLE, WAIT_RDY, ISSUE, DONE.
- **IDLE:**
  - If any `req` bit is high, grant one requester.
  - Latch its `we`, `addr` and `wdata`, plus the grant id.
  - Go to WAIT_RDY.
- **Arbitration:**
  - Single request: grant it.
  - Both requests: grant the requester that is not `last_grant`.
  - `last_grant` updates in DONE.
- **WAIT_RDY:** go to ISSUE when the latched op is ready:
  - addr 00 write: ready when `tbr`=1.
  - addr 00 read: ready when `rda`=1.
  - addr 01, 10, 11 (either direction): always ready, so WAIT_RDY lasts exactly one cycle.
- **ISSUE:**
  - Drive `iocs`=1, `iorw`=~we, `ioaddr`=latched addr.
  - On a write, also drive `databus`=latched wdata.
  - On a read, sample `databus` into `rdata` at the edge ending ISSUE.
  - Go to DONE.
- **DONE:** `ack[grant]`=1 and `err[grant]`=0, then go to IDLE.
- **Requester contract:**
  - Keep `req` high with stable fields until `ack`.
  - Drive `req` low in the cycle after `ack`, unless a new transaction is intended.
  - A requester's `req` is never dropped mid-transaction by the arbiter; its latched copy is used.
- **Bus idle values:** `iocs`=0, `iorw`=1, `ioaddr`=00, `databus`=Z.

## Timing
- **Reset values:**
  - State IDLE, `last_grant`=1 (requester 0 wins the first tie).
  - `ack`=00, `err`=00, `rdata`=00.
  - `iocs`=0, `iorw`=1, `ioaddr`=00, `databus`=Z.
- **Minimum latency:** `req` high in cycle 0 (IDLE) → WAIT_RDY cycle 1 → ISSUE cycle 2 → `ack` in cycle 3.
- **Ready-gated ops:** add one cycle per cycle spent waiting for `tbr`/`rda`.
- **Back-to-back throughput:** one transaction per 4 cycles; the next IDLE arbitrates immediately.
- **Reset mid-operation:**
  - The next cycle is IDLE, with `iocs` deasserted and no `ack` issued.
  - An in-flight write may already have reached the SPART.
- **`req` changes outside IDLE:** ignored. Requester 1's `req` rising while requester 0 is being served is held off until the next IDLE.
- **All bus outputs** are decoded from registered state only, so there is no combinational path from `req` to `iocs`.

## Configuration
- **`SPART_ARB_TIMEOUT_EN` defined:**
  - A 16-bit wait counter clears on entry to WAIT_RDY and increments each cycle there.
  - On reaching `TIMEOUT_CYCLES` without ready, go straight to DONE with `err[grant]`=1.
  - No bus cycle is issued and `rdata` is unchanged.
- **`SPART_ARB_TIMEOUT_EN` undefined:** WAIT_RDY waits indefinitely, and `err` is tied to 00.

## Test plan
- **Reset then write to addr 10:** `rst` for 2 cycles, then `req`=01, `we`=01, addr0=10, wdata0=8'h45. Expect `iocs`=1, `iorw`=0, `ioaddr`=10, `databus`=8'h45 in cycle 2, then `ack`=01 in cycle 3.
- **Tie arbitration:** `req`=11 from reset. Expect requester 0 first, then requester 1, with `ack`=01 then `ack`=10 four cycles apart. With `req` kept at 11 (reasserted after each ack), grants keep alternating.
- **RX read gated on `rda`:** requester 1 reads addr 00 with `rda`=0 for 10 cycles. Expect no `iocs`. Then `rda`=1 with SPART driving 8'hA5: expect an ISSUE read cycle, then `ack`=10 and `rdata`=8'hA5.
- **TX write gated on `tbr`:** `tbr`=0, requester 0 writes 8'h3C to addr 00. Expect `databus`=Z throughout the wait. Then `tbr`=1: expect `databus`=8'h3C in the ISSUE cycle only.
- **Reset mid-wait:** assert `rst` while in WAIT_RDY. Expect `iocs`=0 the next cycle, `ack`=00, and `last_grant`=1.
- **Timeout (macro defined, `TIMEOUT_CYCLES`=8):** read addr 00 with `rda` held at 0. Expect `ack`=01 and `err`=01 after 8 wait cycles, `iocs` never asserted, and `rdata` unchanged.
